// File: rtl/snap_ctrl_pkg.sv
// Shared definitions for the snapshot capture sequencer.
package snap_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      DELAY   = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } snap_state_t;

   localparam int CTRL_ARM_BIT  = 0;
   localparam int CTRL_SOFT_BIT = 1;

   localparam int STAT_DONE_BIT = 31;
   localparam int STAT_BUSY_BIT = 30;

endpackage

// File: rtl/snap_trig_offset_ctrl_rise_edge_det.sv
// One-bit synchronous rising-edge detector. History resets to 1 so a bit that
// is already high when reset releases does not produce an edge.
module rise_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic prev;

   // history register
   always_ff @(posedge clk) begin
      if (rst) prev <= 1'b1;
      else     prev <= din;
   end

   assign rise = din & ~prev;

endmodule

// File: rtl/snap_trig_offset_ctrl.sv
// Capture sequencer: arm, wait for trigger, apply signed offset, stream samples
// into BRAM through one register stage, report done/busy/trigger address.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | inactive, waits for an arm edge
//  ARMED   | waiting for trigger; negative offset keeps writing history
//  DELAY   | positive offset: counting valid samples down to capture start
//  CAPTURE | writing post-trigger samples until remain runs out
//  DONE    | capture complete, waits for the next arm edge
module snap_trig_offset_ctrl
   import snap_ctrl_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              user_clk,
   input  logic              user_rst,
   input  logic [31:0]       ctrl_in,
   input  logic [31:0]       trig_offset,
   input  logic              trig,
   input  logic              din_valid,
   input  logic [DATA_W-1:0] din,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_data,
   output logic              bram_we,
   output logic [31:0]       status_out
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [32:0]       MAX_PRE   = 33'(DEPTH - 1);

   snap_state_t       state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] remain_q, remain_d;
   logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
   logic [31:0]       dly_q, dly_d;
   logic [31:0]       off_q, off_d;
   logic              soft_pend_q, soft_pend_d;

   logic              arm_edge, soft_edge, etrig;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [32:0]       off_mag;
   logic [ADDR_W-1:0] pre_len, pre_remain;
   logic [31:0]       status_d;
   logic              unused_ctrl;

   assign unused_ctrl = ^ctrl_in[31:2];

   rise_edge_det u_arm_det (
      .clk  (user_clk),
      .rst  (user_rst),
      .din  (ctrl_in[CTRL_ARM_BIT]),
      .rise (arm_edge)
   );

   rise_edge_det u_soft_det (
      .clk  (user_clk),
      .rst  (user_rst),
      .din  (ctrl_in[CTRL_SOFT_BIT]),
      .rise (soft_edge)
   );

   assign etrig = din_valid & (trig | soft_pend_q);

   // 33-bit negate so the most negative offset does not overflow; history
   // length saturates at DEPTH-1 so the trigger sample always gets a slot.
   assign off_mag    = 33'd0 - {off_q[31], off_q};
   assign pre_len    = (off_mag >= MAX_PRE) ? LAST_ADDR : off_mag[ADDR_W-1:0];
   assign pre_remain = LAST_ADDR - pre_len;

   // state and counter registers
   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         remain_q    <= '0;
         trig_addr_q <= '0;
         dly_q       <= '0;
         off_q       <= '0;
         soft_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         remain_q    <= remain_d;
         trig_addr_q <= trig_addr_d;
         dly_q       <= dly_d;
         off_q       <= off_d;
         soft_pend_q <= soft_pend_d;
      end
   end

   // next-state, counters and write request; arm overrides everything else
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      remain_d    = remain_q;
      trig_addr_d = trig_addr_q;
      dly_d       = dly_q;
      off_d       = off_q;
      soft_pend_d = soft_pend_q | soft_edge;
      wr_en       = 1'b0;
      wr_addr     = wr_ptr_q;

      if (arm_edge) begin
         state_d     = ARMED;
         wr_ptr_d    = '0;
         off_d       = trig_offset;
         soft_pend_d = 1'b0;
      end else if (din_valid) begin
         unique case (state_q)
            ARMED: begin
               if (etrig) begin
                  soft_pend_d = 1'b0;
                  if (off_q[31]) begin
                     wr_en       = 1'b1;
                     trig_addr_d = wr_ptr_q;
                     wr_ptr_d    = wr_ptr_q + 1'b1;
                     remain_d    = pre_remain;
                     state_d     = (pre_remain == '0) ? DONE : CAPTURE;
                  end else if (off_q == 32'd0) begin
                     wr_en       = 1'b1;
                     wr_addr     = '0;
                     trig_addr_d = '0;
                     wr_ptr_d    = ADDR_W'(1);
                     remain_d    = LAST_ADDR;
                     state_d     = CAPTURE;
                  end else begin
                     dly_d   = off_q - 32'd1;
                     state_d = DELAY;
                  end
               end else if (off_q[31]) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
               end
            end
            DELAY: begin
               if (dly_q == 32'd0) begin
                  wr_en       = 1'b1;
                  wr_addr     = '0;
                  trig_addr_d = '0;
                  wr_ptr_d    = ADDR_W'(1);
                  remain_d    = LAST_ADDR;
                  state_d     = CAPTURE;
               end else begin
                  dly_d = dly_q - 32'd1;
               end
            end
            CAPTURE: begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               remain_d = remain_q - 1'b1;
               if (remain_q == ADDR_W'(1)) state_d = DONE;
            end
            default: ;
         endcase
      end
   end

   // status word derived from the current state
   always_comb begin
      status_d                = '0;
      status_d[STAT_DONE_BIT] = (state_q == DONE);
      status_d[STAT_BUSY_BIT] = (state_q inside {ARMED, DELAY, CAPTURE});
      status_d[ADDR_W-1:0]    = trig_addr_q;
   end

   // write pipeline stage and status register
   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         bram_we    <= 1'b0;
         bram_addr  <= '0;
         bram_data  <= '0;
         status_out <= '0;
      end else begin
         bram_we    <= wr_en;
         status_out <= status_d;
         if (wr_en) begin
            bram_addr <= wr_addr;
            bram_data <= din;
         end
      end
   end

endmodule
